// File: rtl/display_scan.sv
// -----------------------------------------------------------------------------
// display_scan
//
// Scans an 8x8 LED matrix and multiplexes a two-digit 7-segment score display.
// Row 0 shows paddle A, row 7 shows paddle B, and the ball is lit at
// (ballX, ballY). All game inputs are snapshotted once per frame, on the wrap
// out of row 7, so a frame never mixes old and new positions. Every output is
// registered and follows the counter/snapshot state with one cycle of latency.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ballX      in   ball column
//   ballY      in   ball row
//   padA       in   leftmost column of paddle A (row 0)
//   padB       in   leftmost column of paddle B (row 7)
//   playing    in   game-active flag; when low the ball blinks
//   scoreA     in   score shown on digit 0
//   scoreB     in   score shown on digit 1
//   row_sel    out  active-low one-hot row enable
//   col_data   out  active-high column drive, bit i = column i
//   digit_sel  out  active-low digit enable, bit 0 = scoreA digit
//   seg        out  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module display_scan #(
    parameter int ROW_DIV   = 1024,  // clk cycles per row slot, >= 4
    parameter int BLANK_CYC = 16,    // blanking cycles at start of each slot
    parameter int PAD_W     = 3,     // paddle width in columns, 1..8
    parameter int BLINK_BIT = 4      // frame_cnt bit that gates the idle ball
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] ballX,
    input  logic [2:0] ballY,
    input  logic [2:0] padA,
    input  logic [2:0] padB,
    input  logic       playing,
    input  logic [3:0] scoreA,
    input  logic [3:0] scoreB,
    output logic [7:0] row_sel,
    output logic [7:0] col_data,
    output logic [1:0] digit_sel,
    output logic [6:0] seg
);

    localparam int PRE_W = $clog2(ROW_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(ROW_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);

    // Per-frame copy of everything the display depends on.
    typedef struct packed {
        logic [2:0] ball_x;
        logic [2:0] ball_y;
        logic [2:0] pad_a;
        logic [2:0] pad_b;
        logic       playing;
        logic [3:0] score_a;
        logic [3:0] score_b;
    } snap_t;

    // Columns left..left+PAD_W-1, clipped at column 7 (never wraps to 0).
    function automatic logic [7:0] pad_mask(input logic [2:0] left);
        logic [7:0] m;
        int         l;
        m = '0;
        l = int'(left);
        for (int c = 0; c < 8; c++) begin
            if (c >= l && c < l + PAD_W) m[c] = 1'b1;
        end
        return m;
    endfunction

    // Full hex decode, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       row_q, row_d;
    logic             dig_q, dig_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    snap_t            snap_q, snap_d;

    logic [7:0] row_sel_q, row_sel_d;
    logic [7:0] col_data_q, col_data_d;
    logic [1:0] digit_sel_q, digit_sel_d;
    logic [6:0] seg_q, seg_d;

    logic       pre_wrap;
    logic       frame_wrap;
    logic [7:0] row_pat;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        pre_d       = pre_q + PRE_W'(1);
        row_d       = row_q;
        dig_d       = dig_q;
        frame_cnt_d = frame_cnt_q;
        snap_d      = snap_q;
        row_pat     = '0;

        pre_wrap   = (pre_q == PRE_LAST);
        frame_wrap = pre_wrap && (row_q == 3'd7);

        if (pre_wrap) begin
            pre_d = '0;
            row_d = row_q + 3'd1;
            dig_d = ~dig_q;
        end

        // Inputs present on the boundary cycle itself are the ones captured.
        if (frame_wrap) begin
            frame_cnt_d    = frame_cnt_q + 8'd1;
            snap_d.ball_x  = ballX;
            snap_d.ball_y  = ballY;
            snap_d.pad_a   = padA;
            snap_d.pad_b   = padB;
            snap_d.playing = playing;
            snap_d.score_a = scoreA;
            snap_d.score_b = scoreB;
        end

        // Row pattern comes only from the snapshot; contributions are OR-ed.
        if (row_q == 3'd0) row_pat = row_pat | pad_mask(snap_q.pad_a);
        if (row_q == 3'd7) row_pat = row_pat | pad_mask(snap_q.pad_b);
        if (row_q == snap_q.ball_y && (snap_q.playing || frame_cnt_q[BLINK_BIT]))
            row_pat[snap_q.ball_x] = 1'b1;

        if (pre_q >= PRE_BLANK) begin
            row_sel_d   = ~(8'd1 << row_q);
            col_data_d  = row_pat;
            digit_sel_d = ~(2'd1 << dig_q);
            seg_d       = hex7(dig_q ? snap_q.score_b : snap_q.score_a);
        end else begin
            row_sel_d   = 8'hFF;
            col_data_d  = 8'h00;
            digit_sel_d = 2'b11;
            seg_d       = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            row_q       <= '0;
            dig_q       <= 1'b0;
            frame_cnt_q <= '0;
            snap_q      <= '0;
            row_sel_q   <= 8'hFF;
            col_data_q  <= 8'h00;
            digit_sel_q <= 2'b11;
            seg_q       <= 7'h7F;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            pre_q       <= pre_d;
            row_q       <= row_d;
            dig_q       <= dig_d;
            frame_cnt_q <= frame_cnt_d;
            snap_q      <= snap_d;
            row_sel_q   <= row_sel_d;
            col_data_q  <= col_data_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign row_sel   = row_sel_q;
    assign col_data  = col_data_q;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_display_scan.sv
// -----------------------------------------------------------------------------
// tb_display_scan
//
// Self-checking bench for display_scan with ROW_DIV=8, BLANK_CYC=2, PAD_W=3,
// BLINK_BIT=0. A reference model pushes the expected pin state for every
// clock into a queue; a checker pops and compares it one cycle later.
// Directed checks against hand-derived constants cover the main scenarios.
// -----------------------------------------------------------------------------
module tb_display_scan;

    localparam int ROW_DIV = 8;
    localparam int BLANK   = 2;
    localparam int PW      = 3;
    localparam int BB      = 0;
    localparam int FRAME   = 8 * ROW_DIV;

    localparam logic [24:0] BLANK_OUT = {8'hFF, 8'h00, 2'b11, 7'h7F};

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ballX, ballY, padA, padB;
    logic       playing;
    logic [3:0] scoreA, scoreB;
    logic [7:0] row_sel, col_data;
    logic [1:0] digit_sel;
    logic [6:0] seg;

    display_scan #(
        .ROW_DIV  (ROW_DIV),
        .BLANK_CYC(BLANK),
        .PAD_W    (PW),
        .BLINK_BIT(BB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ballX    (ballX),
        .ballY    (ballY),
        .padA     (padA),
        .padB     (padB),
        .playing  (playing),
        .scoreA   (scoreA),
        .scoreB   (scoreB),
        .row_sel  (row_sel),
        .col_data (col_data),
        .digit_sel(digit_sel),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [2:0] bx, by, pa, pb;
        logic       pl;
        logic [3:0] sa, sb;
    } tb_snap_t;

    int          k = 0;          // cycles since reset release = model state index
    tb_snap_t    snap;
    logic [24:0] exp_q[$];

    function automatic logic [7:0] pmask(input logic [2:0] left);
        logic [15:0] w;
        w = ((16'd1 << PW) - 16'd1) << left;
        return w[7:0];
    endfunction

    function automatic logic [24:0] model_out(input int kk, input tb_snap_t s);
        int         p, r, d, fc;
        logic [7:0] col;
        p  = kk % ROW_DIV;
        r  = (kk / ROW_DIV) % 8;
        d  = (kk / ROW_DIV) % 2;
        fc = (kk / FRAME) % 256;
        if (p < BLANK) return BLANK_OUT;
        col = 8'h00;
        if (r == 0) col = col | pmask(s.pa);
        if (r == 7) col = col | pmask(s.pb);
        if (r == int'(s.by) && (s.pl || ((fc >> BB) & 1) == 1)) col[s.bx] = 1'b1;
        return {~(8'd1 << r), col, ~(2'd1 << d), HEX[(d == 1) ? s.sb : s.sa]};
    endfunction

    initial begin
        snap = '{default: '0};
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.push_back(BLANK_OUT);
                k    = 0;
                snap = '{default: '0};
            end else begin
                exp_q.push_back(model_out(k, snap));
                if (k % FRAME == FRAME - 1)
                    snap = '{ballX, ballY, padA, padB, playing, scoreA, scoreB};
                k++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
            else check("scan", {7'd0, row_sel, col_data, digit_sel, seg}, {7'd0, exp_q.pop_front()});
        end
    end

    // ---------------- directed helpers ----------------
    // Returns at posedge+1 where the outputs show state (frame f, row r, pre p).
    task automatic at_slot(input int f, input int r, input int p);
        int target;
        target = f * FRAME + r * ROW_DIV + p + 1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (k >= target) break;
        end
        if (k != target) check("slot_sync", k, target);
    endtask

    task automatic row_check(input string tag, input int f, input int r, input logic [7:0] col);
        at_slot(f, r, BLANK);
        check({tag, "_rowsel"}, {24'd0, row_sel}, {24'd0, ~(8'd1 << r)});
        check({tag, "_col"}, {24'd0, col_data}, {24'd0, col});
    endtask

    task automatic blank_check(input string tag);
        check(tag, {7'd0, row_sel, col_data, digit_sel, seg}, {7'd0, BLANK_OUT});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        ballX   = 3'($urandom);
        ballY   = 3'($urandom);
        padA    = 3'($urandom);
        padB    = 3'($urandom);
        playing = 1'($urandom);
        scoreA  = 4'($urandom);
        scoreB  = 4'($urandom);

        // Reset held with random inputs, then released on a falling edge.
        repeat (4) @(negedge clk);
        blank_check("rst_hold");
        rst_n = 1'b1;

        at_slot(0, 0, 0);
        blank_check("f0_blank0");
        at_slot(0, 0, 1);
        blank_check("f0_blank1");
        row_check("f0_r0", 0, 0, 8'h07);
        check("f0_digit", {30'd0, digit_sel}, {30'd0, 2'b10});
        check("f0_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        row_check("f0_r7", 0, 7, 8'h07);

        // Static frame, captured at the end of frame 0.
        playing = 1'b1; padA = 3'd2; padB = 3'd6; ballX = 3'd4; ballY = 3'd3;
        scoreA = 4'd5; scoreB = 4'd3;
        row_check("static_r0", 1, 0, 8'h1C);
        check("static_dig0", {30'd0, digit_sel}, {30'd0, 2'b10});
        check("static_seg0", {25'd0, seg}, {25'd0, 7'b0010010});
        at_slot(1, 3, 1);
        blank_check("static_blank_r3");
        row_check("static_r3", 1, 3, 8'h10);
        check("static_dig1", {30'd0, digit_sel}, {30'd0, 2'b01});
        check("static_seg1", {25'd0, seg}, {25'd0, 7'b0110000});
        row_check("static_r5", 1, 5, 8'h00);
        row_check("static_r7", 1, 7, 8'hC0);

        // Overlap of ball and paddle, plus clipping at column 7.
        ballY = 3'd0; ballX = 3'd7; padA = 3'd6; padB = 3'd7;
        row_check("clip_r0", 2, 0, 8'hC0);
        row_check("clip_r7", 2, 7, 8'h80);

        // Tear-free: move the ball mid-frame 3.
        ballY = 3'd1; ballX = 3'd3;
        row_check("tear_r0", 3, 0, 8'hC0);
        ballY = 3'd5;
        row_check("tear_old_r1", 3, 1, 8'h08);
        row_check("tear_old_r5", 3, 5, 8'h00);
        row_check("tear_new_r1", 4, 1, 8'h00);
        row_check("tear_new_r5", 4, 5, 8'h08);

        // Blink while idle: ball visible only on odd frame_cnt.
        playing = 1'b0; ballY = 3'd2; ballX = 3'd1;
        row_check("blink5_r0", 5, 0, 8'hC0);
        row_check("blink5_r2", 5, 2, 8'h02);
        row_check("blink5_r7", 5, 7, 8'h80);
        row_check("blink6_r0", 6, 0, 8'hC0);
        row_check("blink6_r2", 6, 2, 8'h00);
        row_check("blink7_r2", 7, 2, 8'h02);

        // Asynchronous reset in the middle of a display window.
        at_slot(8, 3, 4);
        #1;
        rst_n = 1'b0;
        #1;
        blank_check("rst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        at_slot(0, 0, 1);
        blank_check("rst2_blank");
        row_check("rst2_r0", 0, 0, 8'h07);
        check("rst2_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        row_check("rst2_r2", 0, 2, 8'h00);
        row_check("rst2_r7", 0, 7, 8'h07);

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan.md
# display_scan

Downstream consumer of the game-logic outputs: scans the 8x8 LED matrix and multiplexes the two-digit 7-segment score display. Each frame shows paddle A on row 0, paddle B on row 7 and the ball at (ballX, ballY). Inputs are snapshotted once per frame so a frame never tears mid-scan. Outputs drive the board pins directly, through registers.

## Interface
- ROW_DIV, 1024: clk cycles per row slot. Must be ≥ 4.
- BLANK_CYC, 16: blanking cycles at the start of each row slot. Requires 1 ≤ BLANK_CYC < ROW_DIV.
- PAD_W, 3: paddle width in columns, 1..8.
- BLINK_BIT, 4: bit of frame_cnt that gates the ball while idle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ballX  in  3  ball column.
- ballY  in  3  ball row.
- padA  in  3  leftmost column of paddle A (row 0).
- padB  in  3  leftmost column of paddle B (row 7).
- playing  in  1  game-active flag.
- scoreA  in  4  score shown on digit 0.
- scoreB  in  4  score shown on digit 1.
- row_sel  out  8  active-low one-hot row enable.
- col_data  out  8  active-high column drive; bit i = column i.
- digit_sel  out  2  active-low digit enable; bit 0 = scoreA digit.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.

## Operation
- Prescaler `pre` counts 0..ROW_DIV-1 and wraps. On wrap:
  - `row` (3 bit) advances; 7 wraps to 0.
  - `dig` (1 bit) toggles.
- Frame boundary is the wrap with row==7.
  - Snapshot registers load ballX, ballY, padA, padB, playing, scoreA and scoreB.
  - 8-bit `frame_cnt` increments, wrapping.
- Row pattern p(r) is built from the snapshot only; all contributions are OR-ed:
  - r==0: bits padA..min(padA+PAD_W-1, 7) set. Clipped at column 7, never wrapped.
  - r==7: the same rule using padB.
  - r==snapY: bit snapX set, if (snapPlaying | frame_cnt[BLINK_BIT]).
- Display window is pre ≥ BLANK_CYC:
  - row_sel = ~(1<<row).
  - col_data = p(row).
  - digit_sel = ~(1<<dig).
  - seg = hex7(dig ? snapB : snapA).
- Blank window is pre < BLANK_CYC:
  - row_sel = 8'hFF, col_data = 0.
  - digit_sel = 2'b11, seg = 7'h7F.
- hex7 is the full hex decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset (async assert, sync release): pre=0, row=0, dig=0, frame_cnt=0, all snapshots 0.
- Output values during and immediately after reset:
  - row_sel=8'hFF, col_data=0.
  - digit_sel=2'b11, seg=7'h7F.
- All outputs are registered. The output in cycle n+1 reflects the counter/snapshot state of cycle n, so there is exactly 1 cycle of latency.
- After release, the first frame displays the zeroed snapshot: paddles on cols 0..PAD_W-1 of rows 0 and 7, ball on (0,0) blinking.
- Frame period is 8·ROW_DIV cycles.
- Input changes mid-frame have no visible effect until the next frame boundary. An input changing on the exact boundary cycle is captured.
- Reset asserted mid-frame clears all state and blanks all outputs immediately (asynchronous).
- Nothing is dropped at any wrap; every row receives exactly ROW_DIV cycles.

## Test plan
Use ROW_DIV=8, BLANK_CYC=2, PAD_W=3, BLINK_BIT=0.
- Reset: hold rst_n=0 with random inputs, then release.
  - Required: row_sel=FF, col_data=00, digit_sel=11, seg=7F until the first display window.
  - Required: row 0 col_data=07 (pads plus ball at col 0).
- Static frame: playing=1, padA=2, padB=6, ballX=4, ballY=3, scoreA=5, scoreB=3; skip the first frame.
  - Required col_data per row: row 0=1C, row 7=C0, row 3=10, other rows=00.
  - Required seg alternates 0010010 / 0110000 with digit_sel 10 / 01.
- Overlap and clip: ballY=0, ballX=7, padA=6, padB=7, playing=1.
  - Required: row 0=C0 (ball OR paddle), row 7=80.
- Tear-free capture: change ballY mid-frame.
  - Required: the old position persists until the frame boundary; the new position appears in the next frame.
- Blink: playing=0 with ballY=2, ballX=1.
  - Required: row 2 shows 02 on odd frame_cnt frames and 00 on even frames.
  - Required: paddles are unaffected.
- Blanking and reset mid-row: check 2 blank cycles per row slot. Assert rst_n=0 during a display window.
  - Required: outputs go FF/00/11/7F within the same cycle, without waiting for clk.
